// File: rtl/sr_drift_scheduler_pkg.sv
// Shared constants, FSM state type and LFSR step for the SR drift update scheduler.
// Optional build macro SR_DRIFT_SCHED_FAST_SIM_EN shortens every period (see top level).
package sr_drift_pkg;

  localparam int unsigned NUM_SR_HARMONICS = 5;
  localparam int unsigned SR_PERIOD_W      = 24;

  // Listed highest index first so harmonic 0 gets 16000 and harmonic 4 gets 4000.
  localparam logic [NUM_SR_HARMONICS*SR_PERIOD_W-1:0] SR_DEFAULT_PERIODS =
    {24'd4000, 24'd6000, 24'd8000, 24'd12000, 24'd16000};

  localparam logic [15:0]  SR_LFSR_SEED      = 16'hACE1;
  localparam logic [15:0]  SR_LFSR_TAPS      = 16'hB400;
  localparam int unsigned  SR_FAST_SIM_SHIFT = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

  // Fibonacci step, taps 16/14/13/11, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & SR_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sr_drift_scheduler_if.sv
// Grant handshake between the drift scheduler (master) and the drift accumulator (slave).
interface sr_drift_scheduler_if #(
  parameter int unsigned IDX_W = 3
) ();

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_dir;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_dir,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_dir,
    output upd_ready
  );

endinterface

// File: rtl/sr_drift_scheduler_rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping.
module sr_rr_arbiter #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_req_o
);

  int unsigned cand;

  always_comb begin
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_req_o && (|(req_i & (NUM_REQ'(1) << cand)))) begin
        any_req_o = 1'b1;
        gnt_idx_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sr_drift_scheduler.sv
// Per-harmonic period counters, pending/overrun flags and a round-robin grant FSM with LFSR direction.
// Define SR_DRIFT_SCHED_FAST_SIM_EN to use PERIODS[i] >> 6 (floored at 2) for accelerated simulation.
module sr_drift_scheduler
  import sr_drift_pkg::*;
#(
  parameter int unsigned NUM_HARMONICS = NUM_SR_HARMONICS,
  parameter int unsigned PERIOD_W      = SR_PERIOD_W,
  parameter logic [NUM_HARMONICS*PERIOD_W-1:0] PERIODS = SR_DEFAULT_PERIODS,
  parameter logic [15:0] LFSR_SEED     = SR_LFSR_SEED,
  parameter int unsigned IDX_W         = $clog2(NUM_HARMONICS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     freeze,
  sr_drift_scheduler_if.master     upd,
  output logic [NUM_HARMONICS-1:0] pending,
  output logic [NUM_HARMONICS-1:0] overrun
);

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     dir_q, dir_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [NUM_HARMONICS-1:0] pend_q, pend_d;
  logic [NUM_HARMONICS-1:0] ovr_q, ovr_d;

  logic [NUM_HARMONICS-1:0] expire;
  logic [NUM_HARMONICS-1:0] acc_hit;
  logic                     tick;
  logic                     accept;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_any;

  assign tick   = clk_en && !freeze;
  assign accept = (state_q == OFFER) && upd.upd_ready;

  for (genvar g = 0; g < NUM_HARMONICS; g++) begin : g_cnt
    localparam logic [PERIOD_W-1:0] RAW = PERIODS[g*PERIOD_W +: PERIOD_W];
`ifdef SR_DRIFT_SCHED_FAST_SIM_EN
    localparam logic [PERIOD_W-1:0] SHR = RAW >> SR_FAST_SIM_SHIFT;
    localparam logic [PERIOD_W-1:0] EFF = (SHR < PERIOD_W'(2)) ? PERIOD_W'(2) : SHR;
`else
    localparam logic [PERIOD_W-1:0] EFF = RAW;
`endif
    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign expire[g] = tick && (cnt_q == EFF - PERIOD_W'(1));

    always_comb begin
      cnt_d = cnt_q;
      if (tick) cnt_d = expire[g] ? '0 : cnt_q + PERIOD_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  assign acc_hit = accept ? (NUM_HARMONICS'(1) << idx_q) : '0;

  // Expiry wins over a same-cycle accept, and that case is not an overrun.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int unsigned i = 0; i < NUM_HARMONICS; i++) begin
      if (expire[i]) begin
        if (pend_q[i] && !acc_hit[i]) ovr_d[i] = 1'b1;
        pend_d[i] = 1'b1;
      end else if (acc_hit[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  sr_rr_arbiter #(
    .NUM_REQ (NUM_HARMONICS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i     (pend_q),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    rr_ptr_d = rr_ptr_q;
    lfsr_d   = lfsr_q;
    unique case (state_q)
      IDLE: begin
        if (!freeze && arb_any) begin
          idx_d   = arb_idx;
          dir_d   = lfsr_q[0];
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (upd.upd_ready) begin
          rr_ptr_d = (idx_q == IDX_W'(NUM_HARMONICS - 1)) ? '0 : idx_q + IDX_W'(1);
          lfsr_d   = lfsr_step(lfsr_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      rr_ptr_q <= '0;
      lfsr_q   <= LFSR_SEED;
      pend_q   <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      rr_ptr_q <= rr_ptr_d;
      lfsr_q   <= lfsr_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  assign upd.upd_valid = (state_q == OFFER);
  assign upd.upd_idx   = idx_q;
  assign upd.upd_dir   = dir_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;

endmodule
